// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared types and helpers for the GPR writeback arbiter and its scoreboard.
`include "global_defines.vh"

package gpr_wb_arbiter_pkg;

  localparam int unsigned GPR_AW = `GPR_ADDR_W;
  localparam int unsigned GPR_NV = `GPR_NUM;

  typedef enum logic {
    GNT_LSU = 1'b0,
    GNT_ALU = 1'b1
  } gnt_src_e;

  typedef struct packed {
    logic [GPR_AW-1:0] rs1;
    logic [GPR_AW-1:0] rs2;
    logic [GPR_AW-1:0] rd;
    logic              rd_we;
  } iss_req_t;

  // ALU wins only when LSU is idle or the policy currently prefers ALU.
  function automatic logic pick_alu(input logic alu_v, input logic lsu_v,
                                    input logic prefer_lsu);
    return alu_v & (~lsu_v | ~prefer_lsu);
  endfunction

endpackage

// File: rtl/global_defines.vh
// Global widths shared by the GPU core blocks.
`ifndef GLOBAL_DEFINES_VH
`define GLOBAL_DEFINES_VH

`ifndef GPU_DDATA_WIDTH
`define GPU_DDATA_WIDTH 32
`endif

`define GPR_ADDR_W 5
`define GPR_NUM 32

`endif

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard: busy vector with set/clear/flush and issue hazard check.
`include "global_defines.vh"

module gpr_scoreboard
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREG = GPR_NV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              iss_valid,
  input  iss_req_t          iss,
  output logic              iss_ready,
  input  logic              clr_en,
  input  logic [GPR_AW-1:0] clr_addr,
  output logic [NREG-1:0]   busy
);

  localparam int unsigned NV   = 1 << GPR_AW;
  localparam int unsigned NMIN = (NREG < NV) ? NREG : NV;

  logic [NV-1:0]   busy_full;
  logic [NREG-1:0] busy_nxt;
  logic            hazard;
  logic            set_en;

  // Address-space view of the busy vector; register 0 is never busy.
  always_comb begin
    busy_full = '0;
    for (int unsigned i = 0; i < NMIN; i++) begin
      busy_full[i] = busy[i];
    end
    busy_full[0] = 1'b0;
  end

  always_comb begin
    hazard    = busy_full[iss.rs1] | busy_full[iss.rs2] |
                (iss.rd_we & busy_full[iss.rd]);
    iss_ready = ~rst & ~hazard;
    set_en    = iss_valid & iss_ready & iss.rd_we & (iss.rd != '0);
  end

  // Set beats clear on the same register; flush beats both.
  always_comb begin
    busy_nxt = busy;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (clr_en && (clr_addr == GPR_AW'(i))) begin
        busy_nxt[i] = 1'b0;
      end
      if (set_en && (iss.rd == GPR_AW'(i))) begin
        busy_nxt[i] = 1'b1;
      end
    end
    if (flush) begin
      busy_nxt = '0;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Two-source (ALU/LSU) register-file writeback arbiter with pending-write scoreboard.
// Define GPR_WB_RR_EN for round-robin arbitration; default is fixed LSU-over-ALU priority.
`include "global_defines.vh"

module gpr_wb_arbiter
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int unsigned DW   = `GPU_DDATA_WIDTH,
  parameter int unsigned NREG = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_wb_valid,
  output logic              alu_wb_ready,
  input  logic [GPR_AW-1:0] alu_wb_addr,
  input  logic [DW-1:0]     alu_wb_data,
  input  logic              lsu_wb_valid,
  output logic              lsu_wb_ready,
  input  logic [GPR_AW-1:0] lsu_wb_addr,
  input  logic [DW-1:0]     lsu_wb_data,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [GPR_AW-1:0] iss_rs1,
  input  logic [GPR_AW-1:0] iss_rs2,
  input  logic [GPR_AW-1:0] iss_rd,
  input  logic              iss_rd_we,
  input  logic              flush,
  output logic              gpr_wen,
  output logic [GPR_AW-1:0] gpr_waddr,
  output logic [DW-1:0]     gpr_wdata,
  output logic [NREG-1:0]   sb_busy
);

  logic              prefer_lsu;
  logic              alu_gnt;
  logic              lsu_gnt;
  logic              wb_acc;
  gnt_src_e          wb_src;
  logic [GPR_AW-1:0] wb_addr;
  logic [DW-1:0]     wb_data;
  iss_req_t          iss;

  // Grants are combinational from the valids; nothing is granted in reset.
  always_comb begin
    alu_gnt = ~rst & pick_alu(alu_wb_valid, lsu_wb_valid, prefer_lsu);
    lsu_gnt = ~rst & lsu_wb_valid & ~alu_gnt;
  end

  assign alu_wb_ready = alu_gnt;
  assign lsu_wb_ready = lsu_gnt;

`ifdef GPR_WB_RR_EN
  // Round-robin pointer: prefer whichever source was not granted last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prefer_lsu <= 1'b1;
    end else if (alu_gnt || lsu_gnt) begin
      prefer_lsu <= alu_gnt;
    end
  end
`else
  assign prefer_lsu = 1'b1;
`endif

  always_comb begin
    wb_acc  = alu_gnt | lsu_gnt;
    wb_src  = alu_gnt ? GNT_ALU : GNT_LSU;
    wb_addr = (wb_src == GNT_ALU) ? alu_wb_addr : lsu_wb_addr;
    wb_data = (wb_src == GNT_ALU) ? alu_wb_data : lsu_wb_data;
  end

  // Register-file write port, one cycle after accept; x0 writes are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpr_wen   <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
    end else begin
      gpr_wen <= wb_acc & (wb_addr != '0);
      if (wb_acc) begin
        gpr_waddr <= wb_addr;
        gpr_wdata <= wb_data;
      end
    end
  end

  assign iss = '{rs1: iss_rs1, rs2: iss_rs2, rd: iss_rd, rd_we: iss_rd_we};

  gpr_scoreboard #(
    .NREG(NREG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .iss_valid(iss_valid),
    .iss      (iss),
    .iss_ready(iss_ready),
    .clr_en   (wb_acc),
    .clr_addr (wb_addr),
    .busy     (sb_busy)
  );

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed self-checking bench for gpr_wb_arbiter (both arbitration builds).
`timescale 1ns/1ps

module tb_gpr_wb_arbiter;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_wb_valid, lsu_wb_valid;
  logic          alu_wb_ready, lsu_wb_ready;
  logic [4:0]    alu_wb_addr, lsu_wb_addr;
  logic [DW-1:0] alu_wb_data, lsu_wb_data;
  logic          iss_valid, iss_ready, iss_rd_we, flush;
  logic [4:0]    iss_rs1, iss_rs2, iss_rd;
  logic          gpr_wen;
  logic [4:0]    gpr_waddr;
  logic [DW-1:0] gpr_wdata;
  logic [31:0]   sb_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gpr_wb_arbiter #(.DW(DW), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
    .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
    .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_rd_we(iss_rd_we),
    .flush(flush),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .sb_busy(sb_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b0;
    alu_wb_valid = 0; alu_wb_addr = 0; alu_wb_data = 0;
    lsu_wb_valid = 0; lsu_wb_addr = 0; lsu_wb_data = 0;
    iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_rd_we = 0;
    flush = 0;
    #1 rst = 1'b1;
    alu_wb_valid = 1; lsu_wb_valid = 1; iss_valid = 1;
    #1;
    chk("rst_gpr_wen", 64'(gpr_wen), 64'd0);
    chk("rst_waddr", 64'(gpr_waddr), 64'd0);
    chk("rst_wdata", 64'(gpr_wdata), 64'd0);
    chk("rst_sb_busy", 64'(sb_busy), 64'd0);
    chk("rst_alu_ready", 64'(alu_wb_ready), 64'd0);
    chk("rst_lsu_ready", 64'(lsu_wb_ready), 64'd0);
    chk("rst_iss_ready", 64'(iss_ready), 64'd0);
    alu_wb_valid = 0; lsu_wb_valid = 0; iss_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Lone ALU write to x3
    alu_wb_valid = 1; alu_wb_addr = 5'd3; alu_wb_data = 32'h11;
    settle();
    chk("alu_only_ready", 64'(alu_wb_ready), 64'd1);
    chk("alu_only_lsu_ready", 64'(lsu_wb_ready), 64'd0);
    cyc();
    alu_wb_valid = 0;
    chk("alu_only_wen", 64'(gpr_wen), 64'd1);
    chk("alu_only_waddr", 64'(gpr_waddr), 64'd3);
    chk("alu_only_wdata", 64'(gpr_wdata), 64'h11);
    cyc();
    chk("idle_wen", 64'(gpr_wen), 64'd0);

    // Contention: ALU x4, LSU x5
    alu_wb_valid = 1; alu_wb_addr = 5'd4; alu_wb_data = 32'hA4;
    lsu_wb_valid = 1; lsu_wb_addr = 5'd5; lsu_wb_data = 32'hB5;
    settle();
`ifdef GPR_WB_RR_EN
    for (int i = 0; i < 4; i++) begin
      chk("rr_lsu_ready", 64'(lsu_wb_ready), 64'((i % 2) == 0));
      chk("rr_alu_ready", 64'(alu_wb_ready), 64'((i % 2) != 0));
      cyc();
      chk("rr_waddr", 64'(gpr_waddr), ((i % 2) == 0) ? 64'd5 : 64'd4);
      chk("rr_wen", 64'(gpr_wen), 64'd1);
    end
    alu_wb_valid = 0; lsu_wb_valid = 0;
`else
    chk("fp_lsu_ready", 64'(lsu_wb_ready), 64'd1);
    chk("fp_alu_ready", 64'(alu_wb_ready), 64'd0);
    cyc();
    lsu_wb_valid = 0;
    chk("fp_first_waddr", 64'(gpr_waddr), 64'd5);
    chk("fp_first_wdata", 64'(gpr_wdata), 64'hB5);
    settle();
    chk("fp_alu_ready_next", 64'(alu_wb_ready), 64'd1);
    cyc();
    alu_wb_valid = 0;
    chk("fp_second_waddr", 64'(gpr_waddr), 64'd4);
    chk("fp_second_wdata", 64'(gpr_wdata), 64'hA4);
`endif
    cyc();

    // Hazard on x7
    iss_valid = 1; iss_rd = 5'd7; iss_rd_we = 1; iss_rs1 = 0; iss_rs2 = 0;
    settle();
    chk("haz_issue_ready", 64'(iss_ready), 64'd1);
    cyc();
    chk("haz_busy7", 64'(sb_busy), 64'h80);
    iss_rs1 = 5'd7; iss_rd = 5'd8;
    lsu_wb_valid = 1; lsu_wb_addr = 5'd7; lsu_wb_data = 32'h77;
    settle();
    chk("haz_blocked", 64'(iss_ready), 64'd0);
    chk("haz_lsu_ready", 64'(lsu_wb_ready), 64'd1);
    cyc();
    lsu_wb_valid = 0;
    chk("haz_busy_cleared", 64'(sb_busy), 64'd0);
    chk("haz_unblocked", 64'(iss_ready), 64'd1);
    chk("haz_wb_waddr", 64'(gpr_waddr), 64'd7);
    iss_valid = 0; iss_rd_we = 0; iss_rs1 = 0;
    cyc();

    // x0 destination: issue and writeback both leave state alone
    iss_valid = 1; iss_rd = 5'd0; iss_rd_we = 1;
    alu_wb_valid = 1; alu_wb_addr = 5'd0; alu_wb_data = 32'h55;
    settle();
    chk("x0_iss_ready", 64'(iss_ready), 64'd1);
    chk("x0_alu_ready", 64'(alu_wb_ready), 64'd1);
    cyc();
    iss_valid = 0; alu_wb_valid = 0;
    chk("x0_busy", 64'(sb_busy), 64'd0);
    chk("x0_wen", 64'(gpr_wen), 64'd0);

    // Same-cycle set and clear of x9: set wins
    iss_valid = 1; iss_rd = 5'd9; iss_rd_we = 1;
    alu_wb_valid = 1; alu_wb_addr = 5'd9; alu_wb_data = 32'h99;
    settle();
    chk("sc_iss_ready", 64'(iss_ready), 64'd1);
    chk("sc_alu_ready", 64'(alu_wb_ready), 64'd1);
    cyc();
    iss_valid = 0; alu_wb_valid = 0;
    chk("sc_busy9", 64'(sb_busy), 64'h200);
    chk("sc_wdata", 64'(gpr_wdata), 64'h99);
    lsu_wb_valid = 1; lsu_wb_addr = 5'd9; lsu_wb_data = 32'h9A;
    cyc();
    lsu_wb_valid = 0;
    chk("sc_busy9_clear", 64'(sb_busy), 64'd0);

    // Build busy = 0xF00, then flush with a concurrent writeback
    for (int r = 8; r < 12; r++) begin
      iss_valid = 1; iss_rd = 5'(r); iss_rd_we = 1;
      settle();
      chk("fl_build_ready", 64'(iss_ready), 64'd1);
      cyc();
    end
    iss_valid = 0; iss_rd_we = 0;
    chk("fl_busy_f00", 64'(sb_busy), 64'hF00);
    flush = 1;
    alu_wb_valid = 1; alu_wb_addr = 5'd10; alu_wb_data = 32'hAA;
    settle();
    chk("fl_alu_ready", 64'(alu_wb_ready), 64'd1);
    cyc();
    flush = 0; alu_wb_valid = 0;
    chk("fl_busy_zero", 64'(sb_busy), 64'd0);
    chk("fl_wen", 64'(gpr_wen), 64'd1);
    chk("fl_waddr", 64'(gpr_waddr), 64'd10);
    chk("fl_wdata", 64'(gpr_wdata), 64'hAA);

    // Async reset in the middle of a write
    alu_wb_valid = 1; alu_wb_addr = 5'd12; alu_wb_data = 32'hCC;
    iss_valid = 1; iss_rd = 5'd13; iss_rd_we = 1;
    cyc();
    alu_wb_valid = 0;
    chk("mr_wen_before", 64'(gpr_wen), 64'd1);
    chk("mr_busy_before", 64'(sb_busy), 64'h2000);
    #2 rst = 1'b1;
    #1;
    chk("mr_wen", 64'(gpr_wen), 64'd0);
    chk("mr_waddr", 64'(gpr_waddr), 64'd0);
    chk("mr_busy", 64'(sb_busy), 64'd0);
    chk("mr_iss_ready", 64'(iss_ready), 64'd0);
    iss_valid = 0;
    #2 rst = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global timeout so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
